decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline.
- Takes the IF/ID instruction, drives the register-file read addresses combinationally, and registers the decoded control and immediate into the ID/EX boundary. Decoded outputs therefore appear in the same cycle as the register file's registered read data.
- Detects load-use hazards against the instruction currently in EX, requests an upstream stall and inserts a bubble.

Parameters:
- XLEN, 32, datapath and immediate width (only 32 supported)
- RESET_PC, 32'h00000000, value of ex_pc while in reset or flushed

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pipe  in  PipeControl  .flush and .stall from the pipeline controller
- id_valid  in  1  IF/ID holds a real instruction
- id_pc  in  32  PC of id_instr
- id_instr  in  32  instruction word
- r1_addr  out  5  register-file read address 1 (combinational, = id_instr[19:15])
- r2_addr  out  5  register-file read address 2 (combinational, = id_instr[24:20])
- stall_req  out  1  load-use hazard; IF and IF/ID must hold (combinational)
- ex_valid  out  1  registered: EX slot holds a real instruction
- ex_pc  out  32  registered PC
- ex_rd  out  5  registered destination register (0 when no writeback)
- ex_imm  out  32  registered sign-extended immediate
- ex_alu_op  out  4  registered {funct7[5]-qualified bit, funct3}
- ex_alu_src_imm  out  1  ALU B operand = imm
- ex_alu_src_pc  out  1  ALU A operand = pc (AUIPC, JAL, JALR link)
- ex_wb_en  out  1  register write enable
- ex_mem_rd  out  1  load
- ex_mem_wr  out  1  store
- ex_branch  out  1  conditional branch (funct3 in ex_alu_op[2:0])
- ex_jump  out  1  JAL or JALR
- ex_jalr  out  1  JALR target uses rs1

Behaviour:
- Reset: async, active-high. While rst=1 all ex_* outputs = 0 and ex_pc = RESET_PC. stall_req is combinational and reads 0 while rst=1.
- Update priority at each posedge: rst > pipe.flush > pipe.stall > hazard bubble > normal decode.
- pipe.flush: ex_* cleared to the reset values.
- pipe.stall: all ex_* hold their values.
- Latency: 1 cycle from id_instr to ex_*, matching the register-file read latency.
- r1_addr and r2_addr always follow id_instr, regardless of id_valid.
- Immediate formats, all sign-extended from instr[31]:
  - I: LOAD, OP-IMM, JALR
  - S: STORE
  - B: BRANCH, bit0 = 0
  - U: LUI, AUIPC, low 12 bits = 0
  - J: JAL, bit0 = 0
- Shift immediates (funct3 = 001/101) use instr[24:20] zero-extended.
- ex_alu_op[3] = instr[30]:
  - for OP: always
  - for OP-IMM: only when funct3 = 101
  - otherwise 0
- LUI: decoded as rs1 forced to x0 (r1_addr = 0) with alu_src_imm = 1, ADD.
- BRANCH and STORE: ex_rd = 0, wb_en = 0.
- FENCE and SYSTEM: decoded as NOP (valid = 1, all controls 0, rd = 0).
- id_valid = 0: bubble (ex_valid = 0, all controls 0, rd = 0).
- Operand usage:
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP
  - uses_rs2: BRANCH, STORE, OP
- Load-use hazard: stall_req = id_valid & ex_valid & ex_mem_rd & (ex_rd != 0) & ((uses_rs1 & rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd)).
  - When stall_req = 1 and pipe.stall = 0, the next cycle loads a bubble. The held instruction re-decodes on the following cycle; stall_req is then 0 because ex_mem_rd is 0.
  - The register file is not stalled by stall_req, so it re-reads the held addresses.
- pipe.flush overrides hazard: flush and stall_req in the same cycle gives a flushed output.
- A load whose rd = 0 never causes a hazard.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - adds output ex_illegal (1 bit, registered, reset 0).
  - Any opcode outside the RV32I set, or instr[1:0] != 2'b11, gives ex_illegal = 1, ex_valid = 1, all other controls 0, rd = 0.
- Undefined:
  - port absent; such instructions decode as a bubble (ex_valid = 0).

Test Plan:
- Assert rst mid-stream with ex_valid = 1 → all ex_* zero immediately (asynchronous), ex_pc = RESET_PC, stall_req = 0.
- id_instr 0x00500093 (addi x1,x0,5), id_pc 0x100 → r1_addr = 0 same cycle; next cycle ex_rd = 1, ex_imm = 5, ex_alu_src_imm = 1, ex_wb_en = 1, ex_pc = 0x100.
- 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1):
  - stall_req = 1 for exactly one cycle, one bubble (ex_valid = 0).
  - The add then appears with ex_rd = 3, ex_alu_op = 0.
- 0xFE000EE3 (beq x0,x0,-4) → ex_branch = 1, ex_imm = 0xFFFFFFFC, ex_rd = 0, ex_wb_en = 0.
- pipe.stall held 3 cycles with new id_instr, then pipe.flush with stall_req = 1 → ex_* unchanged during stall; flush cycle clears ex_valid = 0.
- id_instr 0xFFFFFFFF:
  - with DECODE_ILLEGAL_TRAP_EN → ex_illegal = 1, ex_valid = 1.
  - without → ex_valid = 0.

Source files
------------

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage : RV32I ID stage; decodes IF/ID into the ID/EX register and
//                detects load-use hazards. Optional: DECODE_ILLEGAL_TRAP_EN.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package decode_stage_pkg;
  typedef struct packed {
    logic flush;
    logic stall;
  } PipeControl;
endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  PipeControl      pipe,
  input  logic            id_valid,
  input  logic [31:0]     id_pc,
  input  logic [31:0]     id_instr,
  output logic [4:0]      r1_addr,
  output logic [4:0]      r2_addr,
  output logic            stall_req,
  output logic            ex_valid,
  output logic [31:0]     ex_pc,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_imm,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_imm,
  output logic            ex_alu_src_pc,
  output logic            ex_wb_en,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_jalr
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic            ex_illegal
`endif
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            alu_src_imm;
    logic            alu_src_pc;
    logic            wb_en;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic            jump;
    logic            jalr;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } ex_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal, uses_rs1, uses_rs2;
  ex_t         dec, ex_d, ex_q, ex_rst;

  assign opcode = id_instr[6:0];
  assign funct3 = id_instr[14:12];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];

  assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
  assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25],
                  id_instr[11:8], 1'b0};
  assign imm_u = {id_instr[31:12], 12'h000};
  assign imm_j = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20],
                  id_instr[30:21], 1'b0};

  assign legal = (opcode == OPC_LUI)    || (opcode == OPC_AUIPC) || (opcode == OPC_JAL)   ||
                 (opcode == OPC_JALR)   || (opcode == OPC_BRANCH)|| (opcode == OPC_LOAD)  ||
                 (opcode == OPC_STORE)  || (opcode == OPC_OPIMM) || (opcode == OPC_OP)    ||
                 (opcode == OPC_FENCE)  || (opcode == OPC_SYSTEM);

  assign uses_rs1 = (opcode == OPC_JALR)  || (opcode == OPC_BRANCH) || (opcode == OPC_LOAD) ||
                    (opcode == OPC_STORE) || (opcode == OPC_OPIMM)  || (opcode == OPC_OP);
  assign uses_rs2 = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);

  // LUI reads x0 so the ALU computes 0 + imm with no special case.
  assign r1_addr = (opcode == OPC_LUI) ? 5'd0 : rs1;
  assign r2_addr = rs2;

  assign stall_req = id_valid && ex_q.valid && ex_q.mem_rd && (ex_q.rd != 5'd0) &&
                     ((uses_rs1 && (rs1 == ex_q.rd)) || (uses_rs2 && (rs2 == ex_q.rd)));

  always_comb begin
    dec    = '0;
    dec.pc = id_pc;
    if (id_valid) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      dec.valid   = 1'b1;
      dec.illegal = ~legal;
`else
      dec.valid   = legal;
`endif
      // Loads and stores carry funct3 so EX/MEM can see the access width.
      case (opcode)
        OPC_LUI: begin
          dec.alu_src_imm = 1'b1;
          dec.wb_en       = 1'b1;
          dec.imm         = imm_u;
        end
        OPC_AUIPC: begin
          dec.alu_src_imm = 1'b1;
          dec.alu_src_pc  = 1'b1;
          dec.wb_en       = 1'b1;
          dec.imm         = imm_u;
        end
        OPC_JAL: begin
          dec.alu_src_pc = 1'b1;
          dec.wb_en      = 1'b1;
          dec.jump       = 1'b1;
          dec.imm        = imm_j;
        end
        OPC_JALR: begin
          dec.alu_src_pc = 1'b1;
          dec.wb_en      = 1'b1;
          dec.jump       = 1'b1;
          dec.jalr       = 1'b1;
          dec.imm        = imm_i;
        end
        OPC_BRANCH: begin
          dec.branch = 1'b1;
          dec.alu_op = {1'b0, funct3};
          dec.imm    = imm_b;
        end
        OPC_LOAD: begin
          dec.alu_src_imm = 1'b1;
          dec.wb_en       = 1'b1;
          dec.mem_rd      = 1'b1;
          dec.alu_op      = {1'b0, funct3};
          dec.imm         = imm_i;
        end
        OPC_STORE: begin
          dec.alu_src_imm = 1'b1;
          dec.mem_wr      = 1'b1;
          dec.alu_op      = {1'b0, funct3};
          dec.imm         = imm_s;
        end
        OPC_OPIMM: begin
          dec.alu_src_imm = 1'b1;
          dec.wb_en       = 1'b1;
          dec.alu_op      = {id_instr[30] && (funct3 == 3'b101), funct3};
          dec.imm         = (funct3[1:0] == 2'b01) ? {27'd0, id_instr[24:20]} : imm_i;
        end
        OPC_OP: begin
          dec.wb_en  = 1'b1;
          dec.alu_op = {id_instr[30], funct3};
        end
        default: ;
      endcase
      if (dec.wb_en) dec.rd = id_instr[11:7];
    end
  end

  always_comb begin
    ex_rst    = '0;
    ex_rst.pc = RESET_PC;
    ex_d      = dec;
    if (stall_req) begin
      ex_d    = '0;
      ex_d.pc = id_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ex_q <= ex_rst;
    else if (pipe.flush) ex_q <= ex_rst;
    else if (!pipe.stall) ex_q <= ex_d;
  end

  assign ex_valid       = ex_q.valid;
  assign ex_pc          = ex_q.pc;
  assign ex_rd          = ex_q.rd;
  assign ex_imm         = ex_q.imm;
  assign ex_alu_op      = ex_q.alu_op;
  assign ex_alu_src_imm = ex_q.alu_src_imm;
  assign ex_alu_src_pc  = ex_q.alu_src_pc;
  assign ex_wb_en       = ex_q.wb_en;
  assign ex_mem_rd      = ex_q.mem_rd;
  assign ex_mem_wr      = ex_q.mem_wr;
  assign ex_branch      = ex_q.branch;
  assign ex_jump        = ex_q.jump;
  assign ex_jalr        = ex_q.jalr;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign ex_illegal     = ex_q.illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// tb_decode_stage : directed bench for decode_stage with a spec-level model.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  PipeControl  pipe;
  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic [4:0]  r1_addr, r2_addr, ex_rd;
  logic        stall_req, ex_valid, ex_alu_src_imm, ex_alu_src_pc, ex_wb_en;
  logic        ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_jalr;
  logic [31:0] ex_pc, ex_imm;
  logic [3:0]  ex_alu_op;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .pipe(pipe), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .r1_addr(r1_addr), .r2_addr(r2_addr), .stall_req(stall_req),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm), .ex_alu_src_pc(ex_alu_src_pc),
    .ex_wb_en(ex_wb_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .ex_illegal(ex_illegal)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected ID/EX contents, computed from the instruction-format rules.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        simm, spc, wb, mrd, mwr, br, jmp, jalr;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        ill;
`endif
  } exp_t;

  function automatic exp_t golden(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [2:0]  f3;
    e    = '0;
    e.pc = pc;
    f3   = ins[14:12];
    i_imm = ins[31:20] - (ins[31] ? 4096 : 0);
    s_imm = {ins[31:25], ins[11:7]} - (ins[31] ? 4096 : 0);
    b_imm = ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2 - (ins[31] ? 4096 : 0);
    u_imm = ins[31:12] * 4096;
    j_imm = ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2 - (ins[31] ? (1 << 20) : 0);
    if (!v) return e;
    e.valid = 1'b1;
    case (ins[6:0])
      7'h37: begin e.simm = 1; e.wb = 1; e.imm = u_imm; end
      7'h17: begin e.simm = 1; e.spc = 1; e.wb = 1; e.imm = u_imm; end
      7'h6F: begin e.spc = 1; e.wb = 1; e.jmp = 1; e.imm = j_imm; end
      7'h67: begin e.spc = 1; e.wb = 1; e.jmp = 1; e.jalr = 1; e.imm = i_imm; end
      7'h63: begin e.br = 1; e.op = {1'b0, f3}; e.imm = b_imm; end
      7'h03: begin e.simm = 1; e.wb = 1; e.mrd = 1; e.op = {1'b0, f3}; e.imm = i_imm; end
      7'h23: begin e.simm = 1; e.mwr = 1; e.op = {1'b0, f3}; e.imm = s_imm; end
      7'h13: begin
        e.simm = 1; e.wb = 1;
        e.op   = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
        e.imm  = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : i_imm;
      end
      7'h33: begin e.wb = 1; e.op = {ins[30], f3}; end
      7'h0F, 7'h73: ;
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        e.ill = 1'b1;
`else
        e.valid = 1'b0;
`endif
      end
    endcase
    if (e.wb) e.rd = ins[11:7];
    return e;
  endfunction

  function automatic logic hazard(input exp_t m, input logic v, input logic [31:0] ins);
    logic u1, u2;
    u1 = ins[6:0] inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    u2 = ins[6:0] inside {7'h63, 7'h23, 7'h33};
    return v && m.valid && m.mrd && (m.rd != 5'd0) &&
           ((u1 && ins[19:15] == m.rd) || (u2 && ins[24:20] == m.rd));
  endfunction

  function automatic exp_t rst_state();
    exp_t e;
    e    = '0;
    e.pc = RPC;
    return e;
  endfunction

  exp_t m;

  always @(posedge clk or posedge rst) begin
    if (rst)                                   m <= rst_state();
    else if (pipe.flush)                       m <= rst_state();
    else if (pipe.stall)                       m <= m;
    else if (hazard(m, id_valid, id_instr))    m <= golden(1'b0, id_pc, id_instr);
    else                                       m <= golden(id_valid, id_pc, id_instr);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("r1_addr", r1_addr, (id_instr[6:0] == 7'h37) ? 5'd0 : id_instr[19:15]);
      chk("r2_addr", r2_addr, id_instr[24:20]);
      chk("stall_req", stall_req, hazard(m, id_valid, id_instr));
      chk("ex_valid", ex_valid, m.valid);
      if (m.valid) chk("ex_pc", ex_pc, m.pc);
      chk("ex_rd", ex_rd, m.rd);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_alu_op", ex_alu_op, m.op);
      chk("ex_ctrl", {ex_alu_src_imm, ex_alu_src_pc, ex_wb_en, ex_mem_rd, ex_mem_wr,
                      ex_branch, ex_jump, ex_jalr},
                     {m.simm, m.spc, m.wb, m.mrd, m.mwr, m.br, m.jmp, m.jalr});
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("ex_illegal", ex_illegal, m.ill);
`endif
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic st);
    id_valid   = v;
    id_pc      = pc;
    id_instr   = ins;
    pipe.flush = fl;
    pipe.stall = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mix [12] = '{32'h123452B7, 32'h00001317, 32'h008000EF, 32'h00008067,
                            32'h0020A423, 32'hFFE09203, 32'h00309293, 32'h4030D293,
                            32'h401101B3, 32'h00209863, 32'h0FF0000F, 32'h00000073};

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) tick();
    chk_en = 1'b1;
    chk("reset ex_valid", ex_valid, 1'b0);
    chk("reset ex_pc", ex_pc, RPC);
    rst = 1'b0;

    // addi x1,x0,5
    drive(1'b1, 32'h100, 32'h00500093, 1'b0, 1'b0);
    #1 chk("addi r1_addr", r1_addr, 5'd0);
    tick();
    chk("addi ex_rd", ex_rd, 5'd1);
    chk("addi ex_imm", ex_imm, 32'd5);
    chk("addi src_imm/wb", {ex_alu_src_imm, ex_wb_en}, 2'b11);
    chk("addi ex_pc", ex_pc, 32'h100);

    // lw x2,0(x1) followed by dependent add x3,x2,x1
    drive(1'b1, 32'h104, 32'h0000A103, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h108, 32'h001101B3, 1'b0, 1'b0);
    #1 chk("lu stall asserted", stall_req, 1'b1);
    tick();
    chk("lu bubble", ex_valid, 1'b0);
    chk("lu stall released", stall_req, 1'b0);
    tick();
    chk("lu add valid", ex_valid, 1'b1);
    chk("lu add rd", ex_rd, 5'd3);
    chk("lu add op", ex_alu_op, 4'd0);

    // beq x0,x0,-4
    drive(1'b1, 32'h10C, 32'hFE000EE3, 1'b0, 1'b0);
    tick();
    chk("beq branch", ex_branch, 1'b1);
    chk("beq imm", ex_imm, 32'hFFFF_FFFC);
    chk("beq rd/wb", {ex_rd, ex_wb_en}, 6'd0);

    // Pipeline stall for three cycles, then flush while a hazard is pending
    drive(1'b1, 32'h200, 32'h0000A103, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h204 + 4 * i, (i == 1) ? 32'h401101B3 : 32'h00110293, 1'b0, 1'b1);
      tick();
      chk("stall hold pc", ex_pc, 32'h200);
      chk("stall hold mem_rd", ex_mem_rd, 1'b1);
    end
    drive(1'b1, 32'h210, 32'h001101B3, 1'b1, 1'b0);
    #1 chk("flush with hazard", stall_req, 1'b1);
    tick();
    chk("flush ex_valid", ex_valid, 1'b0);
    chk("flush ex_pc", ex_pc, RPC);

    // Load into x0 never stalls
    drive(1'b1, 32'h300, 32'h0000A003, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h304, 32'h001001B3, 1'b0, 1'b0);
    #1 chk("x0 load no stall", stall_req, 1'b0);
    tick();

    // Store reading the load result through rs2
    drive(1'b1, 32'h308, 32'h0000A103, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h30C, 32'h0021A023, 1'b0, 1'b0);
    #1 chk("rs2 hazard", stall_req, 1'b1);
    tick();
    tick();
    chk("rs2 store redecoded", ex_mem_wr, 1'b1);

    // Assorted formats: lui, auipc, jal, jalr, sw, lh, slli, srai, sub, bne, fence, ecall
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h400 + 4 * i, mix[i], 1'b0, 1'b0);
      if (i == 0) #1 chk("lui r1_addr forced", r1_addr, 5'd0);
      tick();
      if (i == 0) chk("lui imm", ex_imm, 32'h1234_5000);
      if (i == 5) chk("lh imm", ex_imm, 32'hFFFF_FFFE);
      if (i == 7) chk("srai op/imm", {ex_alu_op, ex_imm}, {4'hD, 32'd3});
    end

    // Illegal word and an invalid slot
    drive(1'b1, 32'h500, 32'hFFFFFFFF, 1'b0, 1'b0);
    tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("illegal trap", {ex_illegal, ex_valid}, 2'b11);
`else
    chk("illegal bubble", ex_valid, 1'b0);
`endif
    drive(1'b0, 32'h504, 32'h00500093, 1'b0, 1'b0);
    tick();
    chk("id_valid=0 bubble", {ex_valid, ex_wb_en, ex_rd}, 7'd0);

    // Asynchronous reset in the middle of a hazard
    drive(1'b1, 32'h600, 32'h0000A103, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h604, 32'h001101B3, 1'b0, 1'b0);
    #1 chk("pre-reset stall", stall_req, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("async rst ex_valid", {ex_valid, ex_mem_rd, ex_wb_en}, 3'd0);
    chk("async rst ex_pc", ex_pc, RPC);
    chk("async rst stall_req", stall_req, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
